// File: rtl/ctrl_pkg.sv
// ctrl_pkg -- shared definitions for the control pipeline.
// Holds the RV32 opcode constants, the writeback-select encoding, the ALU
// operation class, and the decoded control bundle. The bundle is carried
// ID -> EX, and a narrowed copy is carried through MEM into WB.
// Optional feature macro used by control_pipe: CTRL_ILLEGAL_TRAP_EN.
package ctrl_pkg;

  // Major opcodes recognised by the decoder
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Writeback source select
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // ALU operation class handed to the ALU control unit
  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RTYPE  = 2'b10,
    ALU_ITYPE  = 2'b11
  } alu_op_t;

  // Full decoded control bundle, as held in the ID/EX register
  typedef struct packed {
    logic       reg_write;
    alu_op_t    alu_op;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       uilu;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] wb_sel;
  } ctrl_bundle_t;

  // Subset of the bundle still needed once an instruction has left EX
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] wb_sel;
  } mem_ctrl_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;
  localparam mem_ctrl_t    MEM_BUBBLE  = '0;

  // Drop the EX-only fields when an instruction moves into the MEM stages
  function automatic mem_ctrl_t to_mem_ctrl(input ctrl_bundle_t c);
    mem_ctrl_t m;
    m.reg_write = c.reg_write;
    m.mem_read  = c.mem_read;
    m.mem_write = c.mem_write;
    m.wb_sel    = c.wb_sel;
    return m;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode -- purely combinational main decoder.
// Maps a 7-bit opcode onto a control bundle. Anything not in the table
// produces an all-zero bundle (a bubble) and raises the illegal flag; no
// field is ever left undriven, so X never escapes into the pipe.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  output ctrl_bundle_t ctrl,
  output logic         illegal
);

  // Opcode table: start from a bubble and set only the fields each class needs
  always_comb begin
    ctrl    = CTRL_BUBBLE;
    illegal = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_RTYPE;
      end
      OP_ITYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_ITYPE;
        ctrl.alu_src   = 1'b1;
      end
      OP_LOAD: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.wb_sel    = WB_MEM;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.branch    = 1'b1;
        ctrl.alu_op    = ALU_BRANCH;
      end
      OP_JALR: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.wb_sel    = WB_PC4;
      end
      OP_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.wb_sel    = WB_PC4;
      end
      OP_LUI, OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.uilu      = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_pipe.sv
// control_pipe -- pipelined control path: ID/EX register, MEM_LAT MEM-stage
// registers and a MEM/WB register, plus load-use hazard detection.
// ext_stall freezes every stage; hazard_stall and flush_ex inject a bubble
// into EX while the later stages keep draining.
// MEM_LAT must lie in 1..3.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN -- when defined, an unknown
// opcode raises 'illegal' for its EX cycle and bumps a saturating 8-bit
// counter; when undefined both outputs are constant 0 and no counter exists.
module control_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [6:0]            opcode,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  ext_stall,
  input  logic                  flush_ex,
  output logic                  hazard_stall,
  output logic                  ex_valid,
  output logic [1:0]            alu_op,
  output logic                  alu_src,
  output logic                  branch,
  output logic                  jump,
  output logic                  uilu,
  output logic                  mem_valid,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_valid,
  output logic                  reg_write,
  output logic [1:0]            wb_sel,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  illegal,
  output logic [7:0]            illegal_cnt
);

  ctrl_bundle_t dec_ctrl;
  logic         dec_illegal;

  ctrl_decode u_decode (
    .opcode  (opcode),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  // ID/EX register
  logic                  ex_v_q;
  ctrl_bundle_t          ex_ctrl_q;
  logic [REG_ADDR_W-1:0] ex_rd_q;

  // MEM-stage registers; index MEM_LAT-1 is the one presented on the outputs
  logic      [MEM_LAT-1:0]                 mem_v_q;
  mem_ctrl_t [MEM_LAT-1:0]                 mem_ctrl_q;
  logic      [MEM_LAT-1:0][REG_ADDR_W-1:0] mem_rd_q;

  // MEM/WB register
  logic                  wb_v_q;
  logic                  wb_rw_q;
  logic [1:0]            wb_sel_q;
  logic [REG_ADDR_W-1:0] wb_rd_q;

  logic ex_is_load;
  logic rd_match;
  logic id_accept;

  // Load-use detection: a load in EX whose nonzero rd feeds either ID source
  assign ex_is_load   = ex_ctrl_q.mem_read;
  assign rd_match     = (ex_rd_q == rs1) || (ex_rd_q == rs2);
  assign hazard_stall = id_valid && ex_v_q && ex_is_load &&
                        (ex_rd_q != '0) && rd_match;

  // Only a real, legal, unsquashed, non-stalled instruction may enter EX
  assign id_accept = id_valid && !dec_illegal && !hazard_stall && !flush_ex;

  // ID/EX: load the decoded bundle or a bubble; freeze while ext_stall is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_v_q    <= 1'b0;
      ex_ctrl_q <= CTRL_BUBBLE;
      ex_rd_q   <= '0;
    end else if (!ext_stall) begin
      ex_v_q    <= id_accept;
      ex_ctrl_q <= id_accept ? dec_ctrl : CTRL_BUBBLE;
      ex_rd_q   <= id_accept ? rd : '0;
    end
  end

  // MEM chain: shift EX contents through MEM_LAT registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_v_q    <= '0;
      mem_ctrl_q <= '0;
      mem_rd_q   <= '0;
    end else if (!ext_stall) begin
      mem_v_q[0]    <= ex_v_q;
      mem_ctrl_q[0] <= to_mem_ctrl(ex_ctrl_q);
      mem_rd_q[0]   <= ex_rd_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        mem_v_q[i]    <= mem_v_q[i-1];
        mem_ctrl_q[i] <= mem_ctrl_q[i-1];
        mem_rd_q[i]   <= mem_rd_q[i-1];
      end
    end
  end

  // MEM/WB: capture what writeback needs from the last MEM register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_v_q   <= 1'b0;
      wb_rw_q  <= 1'b0;
      wb_sel_q <= WB_ALU;
      wb_rd_q  <= '0;
    end else if (!ext_stall) begin
      wb_v_q   <= mem_v_q[MEM_LAT-1];
      wb_rw_q  <= mem_ctrl_q[MEM_LAT-1].reg_write;
      wb_sel_q <= mem_ctrl_q[MEM_LAT-1].wb_sel;
      wb_rd_q  <= mem_rd_q[MEM_LAT-1];
    end
  end

  assign ex_valid  = ex_v_q;
  assign alu_op    = ex_ctrl_q.alu_op;
  assign alu_src   = ex_ctrl_q.alu_src;
  assign branch    = ex_ctrl_q.branch;
  assign jump      = ex_ctrl_q.jump;
  assign uilu      = ex_ctrl_q.uilu;

  assign mem_valid = mem_v_q[MEM_LAT-1];
  assign mem_read  = mem_ctrl_q[MEM_LAT-1].mem_read;
  assign mem_write = mem_ctrl_q[MEM_LAT-1].mem_write;

  // x0 is hardwired: rd=0 travels through, but never produces a write
  assign wb_valid  = wb_v_q;
  assign reg_write = wb_rw_q && (wb_rd_q != '0);
  assign wb_sel    = wb_sel_q;
  assign wb_rd     = wb_rd_q;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       illegal_q;
  logic [7:0] illegal_cnt_q;
  logic       id_trap;

  // An illegal instruction is "accepted" under the same conditions as a legal one
  assign id_trap = id_valid && dec_illegal && !hazard_stall && !flush_ex;

  // Illegal flag for the EX cycle plus a saturating count of trapped instructions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q     <= 1'b0;
      illegal_cnt_q <= 8'd0;
    end else if (!ext_stall) begin
      illegal_q <= id_trap;
      if (id_trap && (illegal_cnt_q != 8'hFF)) begin
        illegal_cnt_q <= illegal_cnt_q + 8'd1;
      end
    end
  end

  assign illegal     = illegal_q;
  assign illegal_cnt = illegal_cnt_q;
`else
  assign illegal     = 1'b0;
  assign illegal_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe -- scoreboard bench for control_pipe (MEM_LAT=3).
// The driver decodes each issued instruction from the opcode table and
// pushes the expected record, tagged with the pipeline-advance tick at which
// it should sit in EX, onto per-stage queues. The monitor counts advancing
// edges itself and pops a record when its tick for that stage comes due.
// Honours CTRL_ILLEGAL_TRAP_EN in the same way as the design.
module tb_control_pipe;

  localparam int W  = 5;
  localparam int ML = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         id_valid = 1'b0;
  logic [6:0]   opcode = 7'd0;
  logic [W-1:0] rd = '0, rs1 = '0, rs2 = '0;
  logic         ext_stall = 1'b0, flush_ex = 1'b0;
  logic         hazard_stall, ex_valid, alu_src, branch, jump, uilu;
  logic [1:0]   alu_op, wb_sel;
  logic         mem_valid, mem_read, mem_write, wb_valid, reg_write, illegal;
  logic [W-1:0] wb_rd;
  logic [7:0]   illegal_cnt;

  control_pipe #(.REG_ADDR_W(W), .MEM_LAT(ML)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode),
    .rd(rd), .rs1(rs1), .rs2(rs2), .ext_stall(ext_stall), .flush_ex(flush_ex),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .alu_op(alu_op),
    .alu_src(alu_src), .branch(branch), .jump(jump), .uilu(uilu),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .wb_valid(wb_valid), .reg_write(reg_write), .wb_sel(wb_sel), .wb_rd(wb_rd),
    .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       valid;
    bit       rw;
    bit [1:0] alu_op;
    bit       alu_src, branch, jump, uilu, mem_read, mem_write;
    bit [1:0] wb_sel;
    bit [4:0] rd;
    int       tick;
  } rec_t;

  rec_t ex_q[$], mem_q[$], wb_q[$];
  rec_t model_ex, exp_ex, exp_mem, exp_wb;
  int   compared = 0, mismatched = 0;
  int   drv_tick = 0, mon_tick = 0;
  bit   model_ill = 0;
  int   model_cnt = 0;

  function automatic rec_t bubble();
    rec_t r = '{default: 0};
    return r;
  endfunction

  // Reference decode straight from the opcode table
  function automatic rec_t decodeRef(input logic [6:0] op, output bit legal);
    rec_t r = '{default: 0};
    legal = 1;
    case (op)
      7'b0110011: begin r.rw = 1; r.alu_op = 2'b10; end
      7'b0010011: begin r.rw = 1; r.alu_op = 2'b11; r.alu_src = 1; end
      7'b0000011: begin r.rw = 1; r.alu_src = 1; r.mem_read = 1; r.wb_sel = 2'b01; end
      7'b0100011: begin r.mem_write = 1; r.alu_src = 1; end
      7'b1100011: begin r.branch = 1; r.alu_op = 2'b01; end
      7'b1100111: begin r.rw = 1; r.jump = 1; r.alu_src = 1; r.wb_sel = 2'b10; end
      7'b1101111: begin r.rw = 1; r.jump = 1; r.wb_sel = 2'b10; end
      7'b0110111, 7'b0010111: begin r.rw = 1; r.uilu = 1; end
      default: legal = 0;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] allOutputs();
    return {hazard_stall, ex_valid, alu_op, alu_src, branch, jump, uilu,
            mem_valid, mem_read, mem_write, wb_valid, reg_write, wb_sel, wb_rd,
            illegal, illegal_cnt};
  endfunction

  // One ID cycle: drive inputs, check hazard_stall, predict acceptance into EX
  task automatic applyStimulus(input bit v, input logic [6:0] op, input logic [4:0] d,
                               input logic [4:0] s1, input logic [4:0] s2,
                               input bit st, input bit fl, output bit haz);
    rec_t r;
    bit   legal;
    @(negedge clk);
    id_valid = v; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    ext_stall = st; flush_ex = fl;
    #1;
    haz = v && model_ex.valid && model_ex.mem_read && (model_ex.rd != 0) &&
          (model_ex.rd == s1 || model_ex.rd == s2);
    checkOutput("hazard_stall", {31'd0, hazard_stall}, {31'd0, haz});
    if (!st) begin
      drv_tick++;
      r = decodeRef(op, legal);
      if (v && legal && !haz && !fl) begin
        r.valid = 1; r.rd = d; r.tick = drv_tick;
        ex_q.push_back(r); mem_q.push_back(r); wb_q.push_back(r);
        model_ex = r;
      end else begin
        model_ex = bubble();
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      model_ill = v && !legal && !haz && !fl;
      if (model_ill && model_cnt < 255) model_cnt++;
`endif
    end
  endtask

  // Asynchronous reset from mid-cycle; release with a frozen edge so ticks stay aligned
  task automatic resetDut();
    reset = 1'b1; id_valid = 0; flush_ex = 0; ext_stall = 0;
    #1;
    checkOutput("reset_async", allOutputs(), 32'd0);
    ex_q.delete(); mem_q.delete(); wb_q.delete();
    drv_tick = 0; model_ex = bubble(); model_ill = 0; model_cnt = 0;
    repeat (2) @(negedge clk);
    ext_stall = 1'b1;
    reset = 1'b0;
  endtask

  // Monitor: pop expected records when their stage tick comes due, compare every cycle
  always begin
    @(posedge clk);
    #1;
    if (reset) begin
      mon_tick = 0;
      exp_ex = bubble(); exp_mem = bubble(); exp_wb = bubble();
      checkOutput("reset_state", allOutputs(), 32'd0);
    end else begin
      if (!ext_stall) begin
        mon_tick++;
        exp_ex = bubble(); exp_mem = bubble(); exp_wb = bubble();
        if (ex_q.size() > 0 && ex_q[0].tick == mon_tick) exp_ex = ex_q.pop_front();
        if (mem_q.size() > 0 && mem_q[0].tick + ML == mon_tick) exp_mem = mem_q.pop_front();
        if (wb_q.size() > 0 && wb_q[0].tick + ML + 1 == mon_tick) exp_wb = wb_q.pop_front();
      end
      checkOutput("ex_stage", {25'd0, ex_valid, alu_op, alu_src, branch, jump, uilu},
                  {25'd0, exp_ex.valid, exp_ex.alu_op, exp_ex.alu_src, exp_ex.branch,
                   exp_ex.jump, exp_ex.uilu});
      checkOutput("mem_stage", {29'd0, mem_valid, mem_read, mem_write},
                  {29'd0, exp_mem.valid, exp_mem.mem_read, exp_mem.mem_write});
      checkOutput("wb_stage", {23'd0, wb_valid, reg_write, wb_sel, wb_rd},
                  {23'd0, exp_wb.valid, (exp_wb.rw && exp_wb.rd != 0), exp_wb.wb_sel, exp_wb.rd});
      checkOutput("illegal", {31'd0, illegal}, {31'd0, model_ill});
      checkOutput("illegal_cnt", {24'd0, illegal_cnt}, model_cnt);
    end
  end

  logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                          7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111};

  initial begin
    bit         haz;
    int         sel;
    logic [6:0] op;
    logic [4:0] d, s1, s2;
    #2;
    resetDut();

    // R-type latency, then the drained pipe
    applyStimulus(1, 7'b0110011, 5'd3, 5'd1, 5'd2, 0, 0, haz);
    repeat (ML + 2) applyStimulus(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, haz);

    // Load rd=5 followed by a dependent add: one stall, then the add is re-issued
    applyStimulus(1, 7'b0000011, 5'd5, 5'd1, 5'd0, 0, 0, haz);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 7'b0110011, 5'd6, 5'd5, 5'd2, 0, 0, haz);
      if (!haz) break;
    end

    // Load rd=0 followed by an rs1=0 consumer: never a hazard
    applyStimulus(1, 7'b0000011, 5'd0, 5'd1, 5'd0, 0, 0, haz);
    applyStimulus(1, 7'b0110011, 5'd7, 5'd0, 5'd0, 0, 0, haz);

    // JAL in EX frozen for three cycles while flush_ex is held; flush lands at release
    applyStimulus(1, 7'b1101111, 5'd1, 5'd0, 5'd0, 0, 0, haz);
    repeat (3) applyStimulus(1, 7'b0010011, 5'd2, 5'd3, 5'd0, 1, 1, haz);
    applyStimulus(1, 7'b0010011, 5'd2, 5'd3, 5'd0, 0, 1, haz);
    applyStimulus(1, 7'b0010011, 5'd2, 5'd3, 5'd0, 0, 0, haz);

    // Store through the three MEM registers, then reset with it in flight
    applyStimulus(1, 7'b0100011, 5'd0, 5'd4, 5'd5, 0, 0, haz);
    applyStimulus(1, 7'b0110011, 5'd9, 5'd1, 5'd1, 0, 0, haz);
    @(posedge clk);
    #3;
    resetDut();

    // Randomised traffic; a stalled instruction is re-presented like a real ID stage
    haz = 0;
    op = 7'd0; d = 0; s1 = 0; s2 = 0;
    for (int i = 0; i < 600; i++) begin
      bit v, st, fl;
      if (!haz) begin
        sel = $urandom_range(0, 11);
        if (sel < 9) op = ops[sel];
        else if (sel == 9) op = 7'b1111111;
        else op = 7'($urandom);
        d  = 5'($urandom_range(0, 3));
        s1 = 5'($urandom_range(0, 3));
        s2 = 5'($urandom_range(0, 3));
      end
      v  = ($urandom_range(0, 9) < 8) || haz;
      st = ($urandom_range(0, 99) < 15);
      fl = ($urandom_range(0, 99) < 10);
      applyStimulus(v, op, d, s1, s2, st, fl, haz);
    end

    // Long run of illegal opcodes drives the counter into saturation
    repeat (300) applyStimulus(1, 7'b1111111, 5'd1, 5'd0, 5'd0, 0, 0, haz);
`ifdef CTRL_ILLEGAL_TRAP_EN
    checkOutput("illegal_cnt_saturated", {24'd0, illegal_cnt}, 32'd255);
`endif

    // Drain and make sure every issued instruction came out
    repeat (ML + 3) applyStimulus(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, haz);
    checkOutput("ex_queue_drained", ex_q.size(), 32'd0);
    checkOutput("mem_queue_drained", mem_q.size(), 32'd0);
    checkOutput("wb_queue_drained", wb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/control_pipe.md
CONTROL_PIPE -- requirements
Module: control_pipe

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-address width (4 = RV32E).
REQ-002 SHALL have parameter MEM_LAT, default 1, range 1..3, number of MEM-stage control registers between EX and WB.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port id_valid  in  1  ID holds a real instruction.
REQ-006 SHALL have ports opcode  in  7, and rd, rs1, rs2  in  REG_ADDR_W  ID-stage fields.
REQ-007 SHALL have ports ext_stall  in  1  freeze whole pipe; flush_ex  in  1  squash instruction entering EX.
REQ-008 SHALL have port hazard_stall  out  1  load-use stall request to PC/IF-ID.
REQ-009 SHALL have EX outputs ex_valid 1, alu_op 2, alu_src 1, branch 1, jump 1, uilu 1.
REQ-010 SHALL have MEM outputs mem_valid 1, mem_read 1, mem_write 1, taken from the last MEM register.
REQ-011 SHALL have WB outputs wb_valid 1, reg_write 1, wb_sel 2 (00 ALU, 01 memory, 10 PC+4), wb_rd REG_ADDR_W.
REQ-012 SHALL have illegal  out  1 and illegal_cnt  out  8.

Function
REQ-013 SHALL decode: 0110011 rw, alu_op 10; 0010011 rw, alu_op 11, alu_src.
REQ-014 SHALL decode: 0000011 rw, alu_src, mem_read, wb_sel 01; 0100011 mem_write, alu_src.
REQ-015 SHALL decode: 1100011 branch, alu_op 01; 1100111 rw, jump, alu_src, wb_sel 10; 1101111 rw, jump, wb_sel 10.
REQ-016 SHALL decode 0110111 and 0010111 as rw, uilu, with no opcode sharing a row; unlisted opcodes decode as bubble.
REQ-017 SHALL set unlisted fields to 0, never X.
REQ-018 SHALL register the decoded bundle with rd into ID/EX, then through MEM_LAT MEM registers, then MEM/WB; latency ID->EX 1, ID->MEM 1+MEM_LAT, ID->WB 2+MEM_LAT cycles.
REQ-019 SHALL drive hazard_stall combinationally = id_valid & ex_valid & ex_is_load & ex_rd!=0 & (ex_rd==rs1 | ex_rd==rs2).
REQ-020 SHALL load a bubble (all zero, valid 0) into ID/EX when hazard_stall or flush_ex, while later stages advance.
REQ-021 SHALL hold every stage register unchanged while ext_stall=1; ext_stall dominates hazard_stall and flush_ex, and flush_ex SHALL be held by its source until ext_stall falls.
REQ-022 SHALL treat id_valid=0 as a bubble entering ID/EX.
REQ-023 SHALL pass rd=0 through unchanged but force reg_write=0 at WB when wb_rd=0.

Reset
REQ-024 SHALL clear all stage registers, valids, illegal and illegal_cnt to 0 asynchronously on reset.
REQ-025 SHALL output all-zero control during reset and the first cycle after it, with hazard_stall=0.
REQ-026 SHALL discard any in-flight instruction on reset mid-operation, with no partial writeback.

Configuration
REQ-027 SHALL support macro CTRL_ILLEGAL_TRAP_EN.
REQ-028 With CTRL_ILLEGAL_TRAP_EN defined, an unlisted opcode with id_valid SHALL enter EX as a bubble with illegal=1 for that EX cycle (held under ext_stall).
REQ-029 With CTRL_ILLEGAL_TRAP_EN defined, illegal_cnt SHALL increment once per illegal instruction accepted into EX and saturate at 255.
REQ-030 Without CTRL_ILLEGAL_TRAP_EN, illegal and illegal_cnt SHALL be tied to 0 and no counter logic SHALL exist.

Structure
REQ-031 SHALL place the opcode constants, the wb_sel encoding and the ctrl_bundle_t packed struct in shared package ctrl_pkg.
REQ-032 SHALL implement decoding in combinational sub-module ctrl_decode (opcode -> ctrl_bundle_t, illegal flag); stage registers and hazard logic stay in control_pipe.

Verification
REQ-033 SHALL cover: R-type 0110011 at cycle 0 -> ex alu_op=10 at cycle 1; reg_write=1, wb_sel=00 at cycle 3 (MEM_LAT=1).
REQ-034 SHALL cover: load rd=5, then add rs1=5 -> hazard_stall=1 one cycle; one bubble (ex_valid=0); add reaches EX a cycle later.
REQ-035 SHALL cover: load rd=0, then rs1=0 consumer -> hazard_stall stays 0.
REQ-036 SHALL cover: ext_stall high 3 cycles with JAL in EX -> jump held at 1 throughout; flush_ex during stall has no effect until release.
REQ-037 SHALL cover: MEM_LAT=3, store -> mem_write=1 exactly at cycle 4; reset asserted at cycle 2 -> all outputs 0 immediately.
REQ-038 SHALL cover, with CTRL_ILLEGAL_TRAP_EN: 300 illegal opcodes 1111111 -> illegal pulses each EX cycle and illegal_cnt=255.
